timer_multi: RTL and testbench

// - NCH-channel programmable interval timer; generalised successor of the single fixed-period ms timer.
// - Each channel has its own reload value, periodic/one-shot mode, enable and interrupt-pending bit.
// - Sits on the CPU memory-mapped peripheral bus; drives one level IRQ line into the CPU interrupt logic.

---
 rtl/timer_multi_pkg.sv | 13 +
 rtl/timer_channel.sv | 63 ++++++
 rtl/timer_multi.sv | 96 +++++++++
 tb/tb_timer_multi.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_multi_pkg.sv
// Shared register map and CTRL bit positions for the multi-channel interval timer.
package timer_multi_pkg;
    localparam logic [1:0] TMR_REG_CTRL   = 2'd0;
    localparam logic [1:0] TMR_REG_LOAD   = 2'd1;
    localparam logic [1:0] TMR_REG_COUNT  = 2'd2;
    localparam logic [1:0] TMR_REG_STATUS = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IRQ = 2;

    localparam int PRESC_W = 16;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/LOAD/COUNT/pending state and match logic, driven by decoded write strobes.
module timer_channel
    import timer_multi_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_load,
    input  logic             wr_count,
    input  logic             wr_status,
    input  logic [CNT_W-1:0] wdata,
    output logic             en,
    output logic             periodic,
    output logic             irq_en,
    output logic             pending,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] count
);
    logic match;
    assign match = en && tick && (count == load);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            pending  <= 1'b0;
            load     <= '0;
            count    <= '0;
        end else begin
            // A CTRL write overrides the one-shot self-stop on the same edge.
            if (wr_ctrl) begin
                en       <= wdata[CTRL_EN];
                periodic <= wdata[CTRL_PER];
                irq_en   <= wdata[CTRL_IRQ];
            end else if (match && !periodic) begin
                en <= 1'b0;
            end

            if (wr_load)
                load <= wdata;

            if (wr_load)
                count <= '0;
            else if (wr_count)
                count <= wdata;
            else if (match) begin
                if (periodic)
                    count <= '0;
            end else if (en && tick)
                count <= count + CNT_W'(1);

            // Match beats W1C; a LOAD restart suppresses the match.
            if (match && !wr_load)
                pending <= 1'b1;
            else if (wr_status && wdata[0])
                pending <= 1'b0;
        end
    end
endmodule

// File: rtl/timer_multi.sv
// NCH-channel programmable interval timer: address decode, read mux, optional prescaler, IRQ OR.
// Define TIMER_PRESCALE_EN to add the 16-bit PRESC register at the all-ones address.
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              global_int_en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq_pin
);
    localparam int CHW = ADDR_W - 2;

    logic [CHW-1:0] ch_sel;
    logic [1:0]     reg_sel;
    logic           presc_sel;
    logic           tick;

    assign ch_sel  = addr[ADDR_W-1:2];
    assign reg_sel = addr[1:0];

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc, presc_cnt;

    assign presc_sel = (addr == '1);
    assign tick      = (presc_cnt == presc);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (we && presc_sel) begin
            presc     <= wdata[PRESC_W-1:0];
            presc_cnt <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
        end
    end
`else
    assign presc_sel = 1'b0;
    assign tick      = 1'b1;
`endif

    logic [NCH-1:0]            en_q, per_q, irq_en_q, pend_q;
    logic [NCH-1:0][CNT_W-1:0] load_q, count_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        // Channel indices >= NCH match no instance, so those writes fall on the floor.
        assign hit = we && !presc_sel && (ch_sel == CHW'(i));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .clr       (clr),
            .tick      (tick),
            .wr_ctrl   (hit && reg_sel == TMR_REG_CTRL),
            .wr_load   (hit && reg_sel == TMR_REG_LOAD),
            .wr_count  (hit && reg_sel == TMR_REG_COUNT),
            .wr_status (hit && reg_sel == TMR_REG_STATUS),
            .wdata     (wdata[CNT_W-1:0]),
            .en        (en_q[i]),
            .periodic  (per_q[i]),
            .irq_en    (irq_en_q[i]),
            .pending   (pend_q[i]),
            .load      (load_q[i]),
            .count     (count_q[i])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CHW'(i)) begin
                case (reg_sel)
                    TMR_REG_CTRL:   rdata[2:0]       = {irq_en_q[i], per_q[i], en_q[i]};
                    TMR_REG_LOAD:   rdata[CNT_W-1:0] = load_q[i];
                    TMR_REG_COUNT:  rdata[CNT_W-1:0] = count_q[i];
                    default:        rdata[1:0]       = {en_q[i], pend_q[i]};
                endcase
            end
        end
`ifdef TIMER_PRESCALE_EN
        if (presc_sel)
            rdata = {{(32-PRESC_W){1'b0}}, presc};
`endif
    end

    assign irq_pin = global_int_en && |(pend_q & irq_en_q);
endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: rule-level reference model, per-cycle compare, directed pins.
module tb_timer_multi;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        gie = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq_pin;
    logic        run = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    timer_multi #(.NCH(4), .CNT_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .clr           (clr),
        .global_int_en (gie),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .irq_pin       (irq_pin)
    );

    // Reference model: channel state as plain arrays, next state from the behavioural rules.
    logic [31:0] m_load [4];
    logic [31:0] m_cnt  [4];
    logic        m_en   [4];
    logic        m_per  [4];
    logic        m_ie   [4];
    logic        m_pend [4];
    logic [31:0] nx_load [4];
    logic [31:0] nx_cnt  [4];
    logic        nx_en   [4];
    logic        nx_per  [4];
    logic        nx_ie   [4];
    logic        nx_pend [4];
    logic [15:0] m_presc, m_pcnt, nx_presc, nx_pcnt;
    logic        m_tick;

    always_comb begin
        nx_load = m_load; nx_cnt = m_cnt; nx_en = m_en;
        nx_per = m_per; nx_ie = m_ie; nx_pend = m_pend;
        nx_presc = m_presc; nx_pcnt = m_pcnt;
`ifdef TIMER_PRESCALE_EN
        m_tick = (m_pcnt == m_presc);
        if (we && addr == 5'h1f) begin
            nx_presc = wdata[15:0];
            nx_pcnt  = 16'd0;
        end else begin
            nx_pcnt = m_tick ? 16'd0 : m_pcnt + 16'd1;
        end
`else
        m_tick = 1'b1;
`endif
        for (int c = 0; c < 4; c++) begin
            logic mt;
            mt = m_en[c] && m_tick && (m_cnt[c] == m_load[c]);
            if (mt) begin
                nx_pend[c] = 1'b1;
                if (m_per[c]) nx_cnt[c] = 32'd0;
                else          nx_en[c]  = 1'b0;
            end else if (m_en[c] && m_tick) begin
                nx_cnt[c] = m_cnt[c] + 32'd1;
            end
            if (we && addr[4:2] == 3'(c)) begin
                case (addr[1:0])
                    2'd0: begin
                        nx_en[c] = wdata[0]; nx_per[c] = wdata[1]; nx_ie[c] = wdata[2];
                    end
                    2'd1: begin
                        nx_load[c] = wdata; nx_cnt[c] = 32'd0; nx_pend[c] = m_pend[c];
                    end
                    2'd2: nx_cnt[c] = wdata;
                    default: if (wdata[0] && !mt) nx_pend[c] = 1'b0;
                endcase
            end
        end
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int c = 0; c < 4; c++) begin
                m_load[c] <= '0; m_cnt[c] <= '0; m_en[c] <= 1'b0;
                m_per[c] <= 1'b0; m_ie[c] <= 1'b0; m_pend[c] <= 1'b0;
            end
            m_presc <= '0;
            m_pcnt  <= '0;
        end else begin
            m_load <= nx_load; m_cnt <= nx_cnt; m_en <= nx_en;
            m_per <= nx_per; m_ie <= nx_ie; m_pend <= nx_pend;
            m_presc <= nx_presc; m_pcnt <= nx_pcnt;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        int c;
        c = int'(a[4:2]);
`ifdef TIMER_PRESCALE_EN
        if (a == 5'h1f) return {16'd0, m_presc};
`endif
        if (c >= 4) return 32'd0;
        case (a[1:0])
            2'd0:    return {29'd0, m_ie[c], m_per[c], m_en[c]};
            2'd1:    return m_load[c];
            2'd2:    return m_cnt[c];
            default: return {30'd0, m_en[c], m_pend[c]};
        endcase
    endfunction

    function automatic logic exp_irq();
        logic any;
        any = 1'b0;
        for (int c = 0; c < 4; c++) any = any | (m_pend[c] & m_ie[c]);
        return gie & any;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model_rdata", rdata, exp_rd(addr));
            chk("model_irq", {31'd0, irq_pin}, {31'd0, exp_irq()});
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #2;
        we = 1'b0;
    endtask

    int first, second;

    initial begin
        repeat (2) @(posedge clk);
        #2 clr = 1'b0;
        run = 1'b1;

        // Periodic channel 0: LOAD=4 -> COUNT 0..4 then match.
        gie = 1'b1;
        wr(5'h01, 32'd4);
        wr(5'h00, 32'd7);
        addr = 5'h02;
        #1 chk("ch0_count_start", rdata, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #3;
            chk("ch0_count_seq", rdata, 32'(k % 5));
            if (k == 4) chk("ch0_irq_before", {31'd0, irq_pin}, 32'd0);
            if (k == 5) chk("ch0_irq_match", {31'd0, irq_pin}, 32'd1);
        end
        we = 1'b1; addr = 5'h03; wdata = 32'd1;
        @(posedge clk); #2 we = 1'b0;
        #1 chk("ch0_w1c", rdata, 32'd2);
        repeat (3) @(posedge clk);
        #2 we = 1'b1;
        @(posedge clk); #2;
        chk("ch0_set_beats_clear", rdata, 32'd3);
        chk("ch0_set_irq", {31'd0, irq_pin}, 32'd1);
        @(posedge clk); #2 we = 1'b0;
        #1 chk("ch0_clear_next", rdata, 32'd2);
        chk("ch0_clear_irq", {31'd0, irq_pin}, 32'd0);

        // IRQ gating responds without a clock edge.
        repeat (4) @(posedge clk);
        #3 chk("gate_irq_on", {31'd0, irq_pin}, 32'd1);
        gie = 1'b0;
        #1 chk("gate_gie_off", {31'd0, irq_pin}, 32'd0);
        gie = 1'b1;
        #1 chk("gate_gie_on", {31'd0, irq_pin}, 32'd1);
        wr(5'h00, 32'd3);
        #1 chk("gate_irqen_off", {31'd0, irq_pin}, 32'd0);
        wr(5'h00, 32'd7);
        #1 chk("gate_irqen_on", {31'd0, irq_pin}, 32'd1);
        wr(5'h00, 32'd0);
        wr(5'h03, 32'd1);

        // One-shot channel 1: single match, self-stop, COUNT holds.
        wr(5'h05, 32'd2);
        wr(5'h04, 32'd5);
        addr = 5'h07;
        repeat (2) @(posedge clk);
        #3 chk("ch1_running", rdata, 32'd2);
        @(posedge clk);
        #3 chk("ch1_fired", rdata, 32'd1);
        addr = 5'h06;
        #1 chk("ch1_count_hold", rdata, 32'd2);
        repeat (5) @(posedge clk);
        #3 chk("ch1_count_still", rdata, 32'd2);
        addr = 5'h07;
        #1 chk("ch1_no_refire", rdata, 32'd1);
        wr(5'h07, 32'd1);

        // Match period of channel 2 with LOAD=1, optionally prescaled by 4.
`ifdef TIMER_PRESCALE_EN
        wr(5'h1f, 32'd3);
`endif
        wr(5'h09, 32'd1);
        wr(5'h08, 32'd3);
        first = -1; second = -1;
        addr = 5'h0b; wdata = 32'd1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #2 we = 1'b0;
            #1;
            if (rdata[0]) begin
                if (first < 0) first = k;
                else begin second = k; break; end
                we = 1'b1;
            end
        end
        we = 1'b0;
`ifdef TIMER_PRESCALE_EN
        chk("ch2_period", 32'(second - first), 32'd8);
`else
        chk("ch2_period", 32'(second - first), 32'd2);
`endif
        wr(5'h08, 32'd0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            we = ($urandom % 3) == 0;
            if (($urandom % 4) == 0) addr = 5'($urandom % 32);
            else                     addr = 5'($urandom % 16);
            case ($urandom % 4)
                0: wdata = 32'($urandom % 8);
                1: wdata = $urandom;
                2: wdata = 32'hFFFF_FFF8 + 32'($urandom % 8);
                default: wdata = 32'($urandom % 4);
            endcase
            if (addr == 5'h1f) wdata = 32'($urandom % 4);
            if (($urandom % 50) == 0) gie = ~gie;
        end
        we = 1'b0;

        // Async reset mid-count clears everything without a clock edge.
        wr(5'h01, 32'd9);
        wr(5'h00, 32'd7);
        repeat (3) @(posedge clk);
        #2 clr = 1'b1;
        addr = 5'h02;
        #1 chk("rst_count", rdata, 32'd0);
        chk("rst_irq", {31'd0, irq_pin}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            addr = 5'(a);
            #1 chk("rst_regs", rdata, 32'd0);
        end
        repeat (2) @(posedge clk);
        #2 clr = 1'b0;
        repeat (2) @(posedge clk);
        run = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
